// File: rtl/pwl_phase_counter_pkg.sv
// pwl_phase_counter_pkg: state type, default widths and the phase-fraction quantizer
// shared by pwl_phase_counter and pwl_phase_sampler.
// Optional feature macro: PWL_PHASE_COUNTER_FRAC_EN (enables real-valued phase sampling).
package pwl_phase_counter_pkg;

    typedef enum logic [1:0] {IDLE, ARM, MEAS, HOLD} pc_state_t;

    localparam int DEF_NCNT   = 12;
    localparam int DEF_NFRAC  = 8;
    localparam int DEF_WINDOW = 64;

`ifdef PWL_PHASE_COUNTER_FRAC_EN
    localparam real DEF_MODULO = 1.0;

    // floor(v/modulo * 2^nfrac), clamped to [0, 2^nfrac-1]
    function automatic int frac_quant(real v, real modulo, int nfrac);
        real x;
        x = v / modulo * real'(1 << nfrac);
        if (x <= 0.0) return 0;
        if (x >= real'(1 << nfrac)) return (1 << nfrac) - 1;
        return int'($floor(x));
    endfunction
`endif

endpackage

// File: rtl/pwl_phase_sampler.sv
// pwl_phase_sampler: quantizes the integrator's residual phase to an NFRAC-bit fraction
// of one modulo cycle; the parent registers it at the clock edge that needs it.
// Ports: phase_i (real phase, present only with PWL_PHASE_COUNTER_FRAC_EN),
//        frac_o (quantized fraction, constant 0 when the macro is undefined).
module pwl_phase_sampler
    import pwl_phase_counter_pkg::*;
#(
    parameter int NFRAC = DEF_NFRAC
`ifdef PWL_PHASE_COUNTER_FRAC_EN
    , parameter real MODULO = DEF_MODULO
`endif
) (
`ifdef PWL_PHASE_COUNTER_FRAC_EN
    input  real              phase_i,
`endif
    output logic [NFRAC-1:0] frac_o
);

`ifdef PWL_PHASE_COUNTER_FRAC_EN
    assign frac_o = NFRAC'(frac_quant(phase_i, MODULO, NFRAC));
`else
    assign frac_o = '0;
`endif

endmodule

// File: rtl/pwl_phase_counter.sv
// pwl_phase_counter: windowed frequency counter for the PWL phase integrator.
// Counts wrap rising edges over WINDOW clocks and reports Q(NCNT.NFRAC) cycles
// elapsed, with fractional correction from the phase sampled at window open/close.
// Ports: clk_i, rstb_i (async active-low), phase_i (only with PWL_PHASE_COUNTER_FRAC_EN),
//        wrap_i, start_i, ready_i; code_o, valid_o, ovf_o, busy_o.
// wrap_i is sampled by clk_i: a rising edge is seen at the first clock edge where it
// reads high after reading low, so an edge landing on a clock edge belongs to the
// window that edge closes, and one landing on the ARM edge is excluded.
module pwl_phase_counter
    import pwl_phase_counter_pkg::*;
#(
    parameter int NCNT   = DEF_NCNT,
    parameter int NFRAC  = DEF_NFRAC,
    parameter int WINDOW = DEF_WINDOW
`ifdef PWL_PHASE_COUNTER_FRAC_EN
    , parameter real MODULO = DEF_MODULO
`endif
) (
    input  logic                  clk_i,
    input  logic                  rstb_i,
`ifdef PWL_PHASE_COUNTER_FRAC_EN
    input  real                   phase_i,
`endif
    input  logic                  wrap_i,
    input  logic                  start_i,
    input  logic                  ready_i,
    output logic [NCNT+NFRAC-1:0] code_o,
    output logic                  valid_o,
    output logic                  ovf_o,
    output logic                  busy_o
);

    localparam int W  = NCNT + NFRAC;
    localparam int WW = $clog2(WINDOW + 1);

    pc_state_t       state_q, state_d;
    logic [NCNT-1:0] cnt_q, cnt_d;
    logic [WW-1:0]   win_q, win_d;
    logic [NFRAC-1:0] f0_q, f0_d, frac;
    logic [W-1:0]    code_q, code_d;
    logic            wrap_q, ovf_q, ovf_d, rise, full, done, ovf_hit;

    pwl_phase_sampler #(
        .NFRAC(NFRAC)
`ifdef PWL_PHASE_COUNTER_FRAC_EN
        , .MODULO(MODULO)
`endif
    ) u_sampler (
`ifdef PWL_PHASE_COUNTER_FRAC_EN
        .phase_i(phase_i),
`endif
        .frac_o (frac)
    );

    always_comb begin
        rise    = wrap_i & ~wrap_q;
        full    = &cnt_q;
        done    = (state_q == MEAS) && (win_q == WW'(1));
        ovf_hit = (state_q == MEAS) && rise && full;
        state_d = state_q;
        cnt_d   = cnt_q;
        win_d   = win_q;
        f0_d    = f0_q;
        ovf_d   = ovf_q | ovf_hit;
        code_d  = code_q;
        case (state_q)
            IDLE: if (start_i) begin
                state_d = ARM;
                ovf_d   = 1'b0;
            end
            ARM: begin
                f0_d    = frac;
                cnt_d   = '0;
                win_d   = WW'(WINDOW);
                state_d = MEAS;
            end
            MEAS: begin
                win_d = win_q - 1'b1;
                // saturate: the count holds at all ones once it would overflow
                if (rise && !full) cnt_d = cnt_q + 1'b1;
                if (done) begin
                    state_d = HOLD;
                    // f1 < f0 implies at least one wrap, so the borrow from n never underflows
                    code_d  = ovf_d ? '1 : {cnt_d, frac} - W'(f0_q);
                end
            end
            HOLD: if (ready_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rstb_i) begin
        if (!rstb_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            win_q   <= '0;
            f0_q    <= '0;
            code_q  <= '0;
            ovf_q   <= 1'b0;
            wrap_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            win_q   <= win_d;
            f0_q    <= f0_d;
            code_q  <= code_d;
            ovf_q   <= ovf_d;
            wrap_q  <= wrap_i;
        end
    end

    assign code_o  = code_q;
    assign ovf_o   = ovf_q;
    assign valid_o = (state_q == HOLD);
    assign busy_o  = (state_q == ARM) || (state_q == MEAS);

endmodule

// File: tb/tb_pwl_phase_counter.sv
// tb_pwl_phase_counter: randomized self-checking bench for pwl_phase_counter.
// Phase is an unwrapped integer P in 1/1024-cycle units; the expected result is
// floor(P_close) - floor(P_arm) whole cycles plus the fraction difference.
`timescale 1ns/1ps
module tb_pwl_phase_counter;

    logic        clk = 1'b0;
    logic        rstb = 1'b0;
    logic        wrap = 1'b0;
    logic        ready = 1'b0;
    logic [2:0]  start_v = '0;
    real         phase = 0.0;
    logic [19:0] code_a, code_b;
    logic [11:0] code_c;
    logic [2:0]  valid_v, ovf_v, busy_v;

    longint P = 0;
    longint sl = 0;
    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    pwl_phase_counter #(.NCNT(12), .NFRAC(8), .WINDOW(64)) dut_a (
        .clk_i(clk), .rstb_i(rstb),
`ifdef PWL_PHASE_COUNTER_FRAC_EN
        .phase_i(phase),
`endif
        .wrap_i(wrap), .start_i(start_v[0]), .ready_i(ready),
        .code_o(code_a), .valid_o(valid_v[0]), .ovf_o(ovf_v[0]), .busy_o(busy_v[0]));

    pwl_phase_counter #(.NCNT(12), .NFRAC(8), .WINDOW(10)) dut_b (
        .clk_i(clk), .rstb_i(rstb),
`ifdef PWL_PHASE_COUNTER_FRAC_EN
        .phase_i(phase),
`endif
        .wrap_i(wrap), .start_i(start_v[1]), .ready_i(ready),
        .code_o(code_b), .valid_o(valid_v[1]), .ovf_o(ovf_v[1]), .busy_o(busy_v[1]));

    pwl_phase_counter #(.NCNT(4), .NFRAC(8), .WINDOW(40)) dut_c (
        .clk_i(clk), .rstb_i(rstb),
`ifdef PWL_PHASE_COUNTER_FRAC_EN
        .phase_i(phase),
`endif
        .wrap_i(wrap), .start_i(start_v[2]), .ready_i(ready),
        .code_o(code_c), .valid_o(valid_v[2]), .ovf_o(ovf_v[2]), .busy_o(busy_v[2]));

    function automatic int win_of(int s);
        return (s == 0) ? 64 : (s == 1) ? 10 : 40;
    endfunction

    function automatic int ncnt_of(int s);
        return (s == 2) ? 4 : 12;
    endfunction

    function automatic logic [19:0] code_of(int s);
        return (s == 0) ? code_a : (s == 1) ? code_b : {8'h00, code_c};
    endfunction

    // {valid, busy, ovf}
    function automatic logic [2:0] stat_of(int s);
        return {valid_v[s], busy_v[s], ovf_v[s]};
    endfunction

    function automatic longint fq(longint p);
`ifdef PWL_PHASE_COUNTER_FRAC_EN
        return (p % 1024) >> 2;
`else
        return 0 * p;
`endif
    endfunction

    // advance phase and drive inputs 1ns before the rising edge, observe 1ns after
    task automatic tick(input int s, input logic st, input logic rd);
        @(negedge clk);
        #4;
        P += sl;
        phase = real'(P % 1024) / 1024.0;
        wrap = (P % 1024) < 512;
        start_v = st ? 3'(1 << s) : 3'b000;
        ready = rd;
        @(posedge clk);
        #1;
    endtask

    task automatic run_meas(input int s, input longint slope, input longint init, input int hold);
        int w;
        longint pa, pc, n, exp;
        logic eovf, bad_early, bad_hold;
        w = win_of(s);
        sl = slope;
        P = init;
        pa = 0;
        tick(s, 1'b1, 1'b0);
        tests++;
        if (stat_of(s) !== 3'b010)
            $display("FAIL armed dut%0d: status %b want 010", s, stat_of(s));
        bad_early = 1'b0;
        for (int i = 1; i <= w; i++) begin
            tick(s, $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0);
            if (i == 1) pa = P;
            if (stat_of(s)[2:1] !== 2'b01) bad_early = 1'b1;
        end
        tests++;
        if (bad_early) begin
            fails++;
            $display("FAIL window dut%0d: valid early or busy dropped, status %b", s, stat_of(s));
        end
        tick(s, $urandom_range(0, 1) == 1, 1'b0);
        pc = P;
        n = pc / 1024 - pa / 1024;
        eovf = n > (64'd1 << ncnt_of(s)) - 1;
        exp = eovf ? (64'd1 << (ncnt_of(s) + 8)) - 1 : n * 256 + fq(pc) - fq(pa);
        tests++;
        if (stat_of(s) !== {2'b10, eovf}) begin
            fails++;
            $display("FAIL close_status dut%0d: status %b want %b", s, stat_of(s), {2'b10, eovf});
        end
        tests++;
        if (code_of(s) !== 20'(exp)) begin
            fails++;
            $display("FAIL code dut%0d: got %0d want %0d (n=%0d)", s, code_of(s), exp, n);
        end
        bad_hold = 1'b0;
        for (int h = 0; h < hold; h++) begin
            tick(s, $urandom_range(0, 1) == 1, 1'b0);
            if (stat_of(s) !== {2'b10, eovf} || code_of(s) !== 20'(exp)) bad_hold = 1'b1;
        end
        tests++;
        if (bad_hold) begin
            fails++;
            $display("FAIL hold dut%0d: status %b code %0d want %0d", s, stat_of(s), code_of(s), exp);
        end
        tick(s, 1'b0, 1'b1);
        tests++;
        if (stat_of(s)[2:1] !== 2'b00 || code_of(s) !== 20'(exp)) begin
            fails++;
            $display("FAIL release dut%0d: status %b code %0d want valid=0 code %0d", s, stat_of(s), code_of(s), exp);
        end
    endtask

    task automatic test_reset();
        sl = 100;
        repeat (3) tick(0, 1'b1, 1'b0);
        for (int s = 0; s < 3; s++) begin
            tests++;
            if (stat_of(s) !== 3'b000 || code_of(s) !== 20'd0) begin
                fails++;
                $display("FAIL reset dut%0d: status %b code %0d want 000/0", s, stat_of(s), code_of(s));
            end
        end
        #2 rstb = 1'b1;
        tick(0, 1'b0, 1'b0);
        tests++;
        if (stat_of(0) !== 3'b000) begin
            fails++;
            $display("FAIL idle: status %b want 000", stat_of(0));
        end
    endtask

    task automatic test_nominal();
        run_meas(0, 256, 0, 3);
        tests++;
        if (code_a !== 20'd4096) begin
            fails++;
            $display("FAIL nominal: code %0d want 4096", code_a);
        end
        run_meas(1, 307, 308, 5);
        run_meas(1, 256, 0, 5);
    endtask

    task automatic test_coincident();
        // P_close lands exactly on a cycle boundary, so the wrap meets the closing edge
        run_meas(1, 256, 0, 1);
        tests++;
        if (code_b !== 20'(768 - fq(512))) begin
            fails++;
            $display("FAIL coincident: code %0d want %0d", code_b, 768 - fq(512));
        end
    endtask

    task automatic test_ovf();
        run_meas(2, 512, 0, 2);
        tests++;
        if (code_c !== 12'hfff || ovf_v[2] !== 1'b1) begin
            fails++;
            $display("FAIL ovf: code %h ovf %b want fff/1", code_c, ovf_v[2]);
        end
        run_meas(2, 102, 0, 2);
        tests++;
        if (ovf_v[2] !== 1'b0) begin
            fails++;
            $display("FAIL ovf_clear: ovf %b want 0", ovf_v[2]);
        end
    endtask

    task automatic test_reset_mid();
        P = 0;
        sl = 256;
        tick(0, 1'b1, 1'b0);
        repeat (6) tick(0, 1'b0, 1'b0);
        #2 rstb = 1'b0;
        #1;
        tests++;
        if (stat_of(0) !== 3'b000 || code_a !== 20'd0) begin
            fails++;
            $display("FAIL reset_mid: status %b code %0d want 000/0", stat_of(0), code_a);
        end
        #3 rstb = 1'b1;
        run_meas(0, 200, 700, 2);
    endtask

    task automatic test_random();
        for (int k = 0; k < 8; k++)
            run_meas($urandom_range(0, 2), $urandom_range(1, 512), $urandom_range(0, 4095), $urandom_range(0, 4));
    endtask

    task automatic test_back_to_back();
        run_meas(1, 333, 10, 0);
        run_meas(1, 490, 900, 0);
        run_meas(1, 1, 1023, 0);
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_coincident();
        test_ovf();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
